maxpool_layer_param: RTL

MAXPOOL_LAYER_PARAM -- requirements
Module: maxpool_layer_param

---
 rtl/cnn_pkg.sv | 15 +
 rtl/maxpool_cmp4.sv | 22 ++
 rtl/maxpool_layer_param.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: default channel width, packed pixel word and the
// pooling-engine state encoding.
package cnn_pkg;
  localparam int DW_DEF = 16;
  localparam int CH_DEF = 8;

  typedef logic [CH_DEF*DW_DEF-1:0] pixel_t;
  typedef logic signed [DW_DEF-1:0] chan_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/maxpool_cmp4.sv
// Signed maximum of one channel across a 2x2 pooling window.
module maxpool_cmp4
  import cnn_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] c,
  input  logic signed [DW-1:0] d,
  output logic signed [DW-1:0] y
);
  logic signed [DW-1:0] m_top;
  logic signed [DW-1:0] m_bot;

  // Direct signed compares: no subtraction, so the most negative value is safe.
  always_comb begin
    m_top = (a > b) ? a : b;
    m_bot = (c > d) ? c : d;
    y     = (m_top > m_bot) ? m_top : m_bot;
  end
endmodule

// File: rtl/maxpool_layer_param.sv
// 2x2 stride-2 max pooling over a stored IMG_W x IMG_W feature map.
// Define MAXPOOL_RELU_EN to clamp negative pooled channels to zero.
module maxpool_layer_param
  import cnn_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int CH    = 8,
  parameter int DW    = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rd_en,
  output logic [15:0]        rd_row,
  output logic [15:0]        rd_col,
  input  logic [CH*DW-1:0]   in_data,
  output logic               out_valid,
  output logic [15:0]        out_row,
  output logic [15:0]        out_col,
  output logic [CH*DW-1:0]   out_data,
  output logic               busy,
  output logic               done
);
  localparam int          PW   = CH * DW;
  localparam int          AW   = $clog2(IMG_W);
  localparam logic [15:0] LAST = 16'(IMG_W - 1);

  state_t state, state_nxt;

  logic          vld_p0;
  logic [15:0]   row_p0, col_p0;
  logic [PW-1:0] up_p0;
  logic [PW-1:0] prev_p1, diag_p1;
  logic [PW-1:0] pooled;
  logic          fire;
  logic [PW-1:0] linebuf [0:IMG_W-1];

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Drain waits until the last pixel has left the compare stage.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  if (rd_row == LAST && rd_col == LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!vld_p0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == ST_READ);
    busy  = (state != ST_IDLE);
    done  = (state == ST_DRAIN) && !vld_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_row <= '0;
      rd_col <= '0;
    end else if (rd_en) begin
      if (rd_col == LAST) begin
        rd_col <= '0;
        rd_row <= (rd_row == LAST) ? '0 : rd_row + 16'd1;
      end else begin
        rd_col <= rd_col + 16'd1;
      end
    end
  end

  // ---- p0: pixel returned by memory, window assembled from line buffer ----
  assign up_p0 = linebuf[col_p0[AW-1:0]];
  assign fire  = vld_p0 && row_p0[0] && col_p0[0];

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic signed [DW-1:0] mx;
    maxpool_cmp4 #(.DW(DW)) u_cmp (
      .a (diag_p1[k*DW +: DW]),
      .b (up_p0[k*DW +: DW]),
      .c (prev_p1[k*DW +: DW]),
      .d (in_data[k*DW +: DW]),
      .y (mx)
    );
    assign pooled[k*DW +: DW] = relu(mx);
  end

  // diag captures the above-row value before this column is overwritten.
  always_ff @(posedge clk) begin
    row_p0 <= rd_row;
    col_p0 <= rd_col;
    if (vld_p0) begin
      linebuf[col_p0[AW-1:0]] <= in_data;
      prev_p1                 <= in_data;
      diag_p1                 <= up_p0;
    end
  end

  // ---- p1: registered pooled output ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_data  <= '0;
    end else begin
      vld_p0    <= rd_en;
      out_valid <= fire;
      if (fire) begin
        out_row  <= row_p0 >> 1;
        out_col  <= col_p0 >> 1;
        out_data <= pooled;
      end
    end
  end
endmodule
